// File: rtl/subservient_sram_arbiter.sv
// Shares one byte-wide SRAM port between two 32-bit Wishbone masters.
// Port 0 is the CPU core and port 1 is the debug interface. Each granted
// access becomes four little-endian byte cycles on the SRAM. Writes honour
// the byte enables. Reads are reassembled into a 32-bit word and returned
// together with the ack.
module subservient_sram_arbiter #(
  parameter int AW = 13
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_debug_mode,
  // Port 0: CPU core
  input  logic [31:0]   i_wb_m0_adr,
  input  logic [31:0]   i_wb_m0_dat,
  input  logic [3:0]    i_wb_m0_sel,
  input  logic          i_wb_m0_we,
  input  logic          i_wb_m0_stb,
  output logic [31:0]   o_wb_m0_rdt,
  output logic          o_wb_m0_ack,
  // Port 1: debug interface
  input  logic [31:0]   i_wb_m1_adr,
  input  logic [31:0]   i_wb_m1_dat,
  input  logic [3:0]    i_wb_m1_sel,
  input  logic          i_wb_m1_we,
  input  logic          i_wb_m1_stb,
  output logic [31:0]   o_wb_m1_rdt,
  output logic          o_wb_m1_ack,
  // Byte-wide SRAM
  output logic [AW-1:0] o_sram_waddr,
  output logic [7:0]    o_sram_wdata,
  output logic          o_sram_wen,
  output logic [AW-1:0] o_sram_raddr,
  input  logic [7:0]    i_sram_rdata,
  output logic          o_sram_ren
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    LAST = 2'd2,
    ACK  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          last_grant_q, last_grant_d;
  logic          port_q, port_d;
  logic [AW-3:0] adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic [3:0]    sel_q, sel_d;
  logic          we_q, we_d;
  // Bytes 0..2 of a read in progress; byte 3 arrives in LAST and the
  // whole word is copied to the port's rdt register in one go, so a
  // port's rdt never shows a half-assembled word.
  logic [23:0]   rbuf_q, rbuf_d;
  logic [31:0]   rdt0_q, rdt0_d;
  logic [31:0]   rdt1_q, rdt1_d;

  logic          req0;
  logic          req1;
  logic          grant1;

  // Latched write data split into byte lanes, selected by the byte counter.
  logic [7:0]    dat_byte [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_dat_byte
    assign dat_byte[gi] = dat_q[8*gi +: 8];
  end

  // Debug mode only masks the core at arbitration time; an in-flight core
  // transaction is not affected by it.
  assign req0 = i_wb_m0_stb & ~i_debug_mode;
  assign req1 = i_wb_m1_stb;

  // Port 1 wins when it is alone, or on contention when port 0 was
  // served last (last_grant_q == 0).
  assign grant1 = req1 & (~req0 | ~last_grant_q);

  // Address and data lines follow the latched request and byte counter;
  // they may hold stale values while the enables are low.
  assign o_sram_waddr = {adr_q, cnt_q};
  assign o_sram_raddr = {adr_q, cnt_q};
  assign o_sram_wdata = dat_byte[cnt_q];

  assign o_wb_m0_rdt  = rdt0_q;
  assign o_wb_m1_rdt  = rdt1_q;

  // Next-state, request latching, read reassembly and per-state outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    port_d       = port_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    sel_d        = sel_q;
    we_d         = we_q;
    rbuf_d       = rbuf_q;
    rdt0_d       = rdt0_q;
    rdt1_d       = rdt1_q;
    o_sram_wen   = 1'b0;
    o_sram_ren   = 1'b0;
    o_wb_m0_ack  = 1'b0;
    o_wb_m1_ack  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          port_d       = grant1;
          last_grant_d = grant1;
          adr_d        = grant1 ? i_wb_m1_adr[AW-1:2] : i_wb_m0_adr[AW-1:2];
          dat_d        = grant1 ? i_wb_m1_dat : i_wb_m0_dat;
          sel_d        = grant1 ? i_wb_m1_sel : i_wb_m0_sel;
          we_d         = grant1 ? i_wb_m1_we  : i_wb_m0_we;
          cnt_d        = 2'd0;
          state_d      = XFER;
        end
      end

      XFER: begin
        o_sram_wen = we_q & sel_q[cnt_q];
        o_sram_ren = ~we_q;
        // The SRAM returns the previous cycle's byte one cycle late.
        if (!we_q && (cnt_q != 2'd0)) begin
          rbuf_d[{cnt_q - 2'd1, 3'b000} +: 8] = i_sram_rdata;
        end
        if (cnt_q == 2'd3) begin
          cnt_d   = 2'd0;
          state_d = we_q ? ACK : LAST;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end

      LAST: begin
        if (port_q) begin
          rdt1_d = {i_sram_rdata, rbuf_q};
        end else begin
          rdt0_d = {i_sram_rdata, rbuf_q};
        end
        state_d = ACK;
      end

      ACK: begin
        o_wb_m0_ack = ~port_q;
        o_wb_m1_ack = port_q;
        state_d     = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset aborts any transaction without an ack.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      adr_q        <= '0;
      dat_q        <= 32'd0;
      sel_q        <= 4'd0;
      we_q         <= 1'b0;
      rbuf_q       <= 24'd0;
      rdt0_q       <= 32'd0;
      rdt1_q       <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      sel_q        <= sel_d;
      we_q         <= we_d;
      rbuf_q       <= rbuf_d;
      rdt0_q       <= rdt0_d;
      rdt1_q       <= rdt1_d;
    end
  end

  // Address bits outside the SRAM word range are intentionally ignored.
  logic unused_adr_bits;
  assign unused_adr_bits = ^{i_wb_m0_adr[31:AW], i_wb_m0_adr[1:0],
                             i_wb_m1_adr[31:AW], i_wb_m1_adr[1:0]};

endmodule

// File: tb/tb_subservient_sram_arbiter.sv
// Bench for subservient_sram_arbiter: directed transactions, a
// transaction-level reference model checked every cycle, and literal
// expectations for latency, byte traffic and read data.
module tb_subservient_sram_arbiter;
  localparam int AW = 13;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_debug_mode;
  logic [31:0]   i_wb_m0_adr, i_wb_m0_dat;
  logic [3:0]    i_wb_m0_sel;
  logic          i_wb_m0_we, i_wb_m0_stb;
  logic [31:0]   o_wb_m0_rdt;
  logic          o_wb_m0_ack;
  logic [31:0]   i_wb_m1_adr, i_wb_m1_dat;
  logic [3:0]    i_wb_m1_sel;
  logic          i_wb_m1_we, i_wb_m1_stb;
  logic [31:0]   o_wb_m1_rdt;
  logic          o_wb_m1_ack;
  logic [AW-1:0] o_sram_waddr, o_sram_raddr;
  logic [7:0]    o_sram_wdata;
  logic          o_sram_wen, o_sram_ren;
  logic [7:0]    i_sram_rdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  subservient_sram_arbiter #(.AW(AW)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_debug_mode (i_debug_mode),
    .i_wb_m0_adr  (i_wb_m0_adr),
    .i_wb_m0_dat  (i_wb_m0_dat),
    .i_wb_m0_sel  (i_wb_m0_sel),
    .i_wb_m0_we   (i_wb_m0_we),
    .i_wb_m0_stb  (i_wb_m0_stb),
    .o_wb_m0_rdt  (o_wb_m0_rdt),
    .o_wb_m0_ack  (o_wb_m0_ack),
    .i_wb_m1_adr  (i_wb_m1_adr),
    .i_wb_m1_dat  (i_wb_m1_dat),
    .i_wb_m1_sel  (i_wb_m1_sel),
    .i_wb_m1_we   (i_wb_m1_we),
    .i_wb_m1_stb  (i_wb_m1_stb),
    .o_wb_m1_rdt  (o_wb_m1_rdt),
    .o_wb_m1_ack  (o_wb_m1_ack),
    .o_sram_waddr (o_sram_waddr),
    .o_sram_wdata (o_sram_wdata),
    .o_sram_wen   (o_sram_wen),
    .o_sram_raddr (o_sram_raddr),
    .i_sram_rdata (i_sram_rdata),
    .o_sram_ren   (o_sram_ren)
  );

  // ---------------- SRAM environment (driven by the DUT) ----------------
  typedef struct packed {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_t;

  logic [7:0] mem [2**AW];
  wr_t        wlog [$];

  always @(posedge i_clk) begin
    if (o_sram_wen) begin
      mem[o_sram_waddr] <= o_sram_wdata;
      wlog.push_back({o_sram_waddr, o_sram_wdata});
    end
    if (o_sram_ren) i_sram_rdata <= mem[o_sram_raddr];
  end

  // ---------------- Transaction-level reference model ----------------
  // A granted access occupies cycles t=1..4 for the byte transfers and acks
  // at t=5 (write) or t=6 (read); the model is idle for one cycle after
  // that and arbitrates at the end of each idle cycle.
  bit            m_valid = 1'b0;
  bit            m_busy, m_port, m_we, m_last, m_r0, m_r1;
  int            m_t;
  logic [AW-3:0] m_adr;
  logic [31:0]   m_dat, m_word;
  logic [3:0]    m_sel;
  logic [31:0]   m_rdt [2];
  logic [7:0]    exp_mem [2**AW];

  initial forever begin
    @(posedge i_clk);
    if (i_rst) begin
      m_busy   = 1'b0;
      m_last   = 1'b1;
      m_rdt[0] = 32'd0;
      m_rdt[1] = 32'd0;
      m_t      = 0;
      m_valid  = 1'b1;
    end else if (!m_busy) begin
      m_r0 = i_wb_m0_stb && !i_debug_mode;
      m_r1 = i_wb_m1_stb;
      if (m_r0 || m_r1) begin
        m_port = (m_r0 && m_r1) ? !m_last : m_r1;
        m_last = m_port;
        m_adr  = m_port ? i_wb_m1_adr[AW-1:2] : i_wb_m0_adr[AW-1:2];
        m_dat  = m_port ? i_wb_m1_dat : i_wb_m0_dat;
        m_sel  = m_port ? i_wb_m1_sel : i_wb_m0_sel;
        m_we   = m_port ? i_wb_m1_we  : i_wb_m0_we;
        m_busy = 1'b1;
        m_t    = 1;
        for (int k = 0; k < 4; k++) begin
          if (m_we && m_sel[k]) exp_mem[{m_adr, k[1:0]}] = m_dat[8*k +: 8];
        end
        m_word = {exp_mem[{m_adr, 2'd3}], exp_mem[{m_adr, 2'd2}],
                  exp_mem[{m_adr, 2'd1}], exp_mem[{m_adr, 2'd0}]};
      end
    end else if (m_t == (m_we ? 5 : 6)) begin
      m_busy = 1'b0;
    end else begin
      m_t = m_t + 1;
      if (!m_we && m_t == 6) m_rdt[m_port] = m_word;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, sampled on the falling edge.
  initial forever begin
    @(negedge i_clk);
    if (m_valid) begin
      automatic bit xfer = m_busy && m_t >= 1 && m_t <= 4;
      automatic int bi   = xfer ? m_t - 1 : 0;
      automatic bit e_ack = m_busy && m_t == (m_we ? 5 : 6);
      automatic bit e_wen = xfer && m_we && m_sel[bi];
      automatic bit e_ren = xfer && !m_we;
      check("m0_ack", {31'd0, o_wb_m0_ack}, {31'd0, e_ack && !m_port});
      check("m1_ack", {31'd0, o_wb_m1_ack}, {31'd0, e_ack && m_port});
      check("sram_wen", {31'd0, o_sram_wen}, {31'd0, e_wen});
      check("sram_ren", {31'd0, o_sram_ren}, {31'd0, e_ren});
      check("m0_rdt", o_wb_m0_rdt, m_rdt[0]);
      check("m1_rdt", o_wb_m1_rdt, m_rdt[1]);
      if (e_wen) begin
        check("sram_waddr", {19'd0, o_sram_waddr}, {19'd0, m_adr, 2'(bi)});
        check("sram_wdata", {24'd0, o_sram_wdata}, {24'd0, m_dat[8*bi +: 8]});
      end
      if (e_ren) check("sram_raddr", {19'd0, o_sram_raddr}, {19'd0, m_adr, 2'(bi)});
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic wr_t wlog_at(input int k);
    if (k < wlog.size()) return wlog[k];
    return '0;
  endfunction

  // One transaction from idle: returns cycles from grant cycle to ack and
  // the port's read data seen in the ack cycle; leaves the DUT idle.
  task automatic do_txn(input bit p, input bit we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel,
                        output int lat, output logic [31:0] rdt);
    if (p) begin
      i_wb_m1_adr = adr; i_wb_m1_dat = dat; i_wb_m1_sel = sel;
      i_wb_m1_we = we; i_wb_m1_stb = 1'b1;
    end else begin
      i_wb_m0_adr = adr; i_wb_m0_dat = dat; i_wb_m0_sel = sel;
      i_wb_m0_we = we; i_wb_m0_stb = 1'b1;
    end
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!(p ? o_wb_m1_ack : o_wb_m0_ack) && lat < 40);
    rdt = p ? o_wb_m1_rdt : o_wb_m0_rdt;
    i_wb_m0_stb = 1'b0;
    i_wb_m1_stb = 1'b0;
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- Directed tests ----------------
  initial begin
    int          lat, n, cyc, a0, a1;
    int          seq [$];
    logic [31:0] rdt;
    logic [7:0]  wb [4];
    wr_t         e;

    i_rst = 1'b1; i_debug_mode = 1'b0;
    i_wb_m0_adr = '0; i_wb_m0_dat = '0; i_wb_m0_sel = '0; i_wb_m0_we = 1'b0; i_wb_m0_stb = 1'b0;
    i_wb_m1_adr = '0; i_wb_m1_dat = '0; i_wb_m1_sel = '0; i_wb_m1_we = 1'b0; i_wb_m1_stb = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_m0_rdt", o_wb_m0_rdt, 32'd0);
    check("rst_m1_rdt", o_wb_m1_rdt, 32'd0);
    check("rst_enables", {30'd0, o_sram_wen, o_sram_ren}, 32'd0);
    check("rst_acks", {30'd0, o_wb_m0_ack, o_wb_m1_ack}, 32'd0);

    // Both masters writing continuously from reset: m0, m1, m0, m1.
    i_wb_m0_adr = 32'h44; i_wb_m0_dat = 32'h01020304; i_wb_m0_sel = 4'hF; i_wb_m0_we = 1'b1;
    i_wb_m1_adr = 32'h54; i_wb_m1_dat = 32'h05060708; i_wb_m1_sel = 4'hF; i_wb_m1_we = 1'b1;
    i_wb_m0_stb = 1'b1; i_wb_m1_stb = 1'b1;
    tick();
    i_rst = 1'b0;
    n = 0; cyc = 0;
    while (n < 4 && cyc < 200) begin
      tick(); cyc++;
      if (o_wb_m0_ack) seq.push_back(0);
      if (o_wb_m1_ack) seq.push_back(1);
      if (o_wb_m0_ack || o_wb_m1_ack) n++;
    end
    i_wb_m0_stb = 1'b0; i_wb_m1_stb = 1'b0;
    tick();
    check("rr_ack_count", n, 4);
    for (int k = 0; k < 4; k++)
      check("rr_order", (k < seq.size()) ? seq[k] : 32'hFF, k % 2);
    $display("rr: %0d acks in %0d cycles", n, cyc);

    // Debug mode with both strobes: only m1 is served.
    i_debug_mode = 1'b1;
    i_wb_m0_adr = 32'h40; i_wb_m1_adr = 32'h50; i_wb_m1_dat = 32'h0BADF00D;
    i_wb_m0_stb = 1'b1; i_wb_m1_stb = 1'b1;
    a0 = 0; a1 = 0; cyc = 0;
    while (a1 < 3 && cyc < 200) begin
      tick(); cyc++;
      if (o_wb_m0_ack) a0++;
      if (o_wb_m1_ack) a1++;
    end
    i_wb_m0_stb = 1'b0; i_wb_m1_stb = 1'b0;
    tick();
    i_debug_mode = 1'b0;
    check("dbg_m0_acks", a0, 0);
    check("dbg_m1_acks", a1, 3);
    $display("dbg: m0 acks %0d, m1 acks %0d", a0, a1);

    // Port 0 full-word write.
    wlog.delete();
    do_txn(1'b0, 1'b1, 32'h10, 32'hA1B2C3D4, 4'hF, lat, rdt);
    check("w0_latency", lat, 5);
    check("w0_nbytes", wlog.size(), 4);
    wb = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    for (int k = 0; k < 4; k++) begin
      e.a = AW'(32'h10 + k); e.d = wb[k];
      check("w0_byte", {11'd0, wlog_at(k)}, {11'd0, e});
    end
    $display("w0: lat %0d, %0d bytes", lat, wlog.size());

    // Port 0 read back.
    do_txn(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, lat, rdt);
    check("r0_latency", lat, 6);
    check("r0_data", rdt, 32'hA1B2C3D4);
    $display("r0: lat %0d, rdt %h", lat, rdt);

    // Port 1 partial write, sel = 0101.
    wlog.delete();
    do_txn(1'b1, 1'b1, 32'h20, 32'h11223344, 4'b0101, lat, rdt);
    check("w1_latency", lat, 5);
    check("w1_nbytes", wlog.size(), 2);
    e.a = AW'(32'h20); e.d = 8'h44;
    check("w1_byte0", {11'd0, wlog_at(0)}, {11'd0, e});
    e.a = AW'(32'h22); e.d = 8'h22;
    check("w1_byte2", {11'd0, wlog_at(1)}, {11'd0, e});
    $display("w1: lat %0d, %0d bytes", lat, wlog.size());

    // Empty byte-enable write still runs to an ack; m0 rdt untouched.
    wlog.delete();
    do_txn(1'b0, 1'b1, 32'h30, 32'hFFFFFFFF, 4'h0, lat, rdt);
    check("w0_sel0_latency", lat, 5);
    check("w0_sel0_nbytes", wlog.size(), 0);
    check("w0_sel0_rdt_kept", rdt, 32'hA1B2C3D4);
    $display("w0 sel0: lat %0d", lat);

    // Port 1 read of the same word; port 0's rdt stays put.
    do_txn(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, lat, rdt);
    check("r1_latency", lat, 6);
    check("r1_data", rdt, 32'hA1B2C3D4);
    check("r1_m0_rdt_kept", o_wb_m0_rdt, 32'hA1B2C3D4);
    $display("r1: lat %0d, rdt %h", lat, rdt);

    // Debug mode rising and request changes mid-flight do not disturb a
    // granted core write.
    wlog.delete();
    i_wb_m0_adr = 32'h60; i_wb_m0_dat = 32'h55667788; i_wb_m0_sel = 4'hF;
    i_wb_m0_we = 1'b1; i_wb_m0_stb = 1'b1;
    tick(); tick();
    i_debug_mode = 1'b1; i_wb_m0_dat = 32'hDEADBEEF; i_wb_m0_adr = 32'h70;
    lat = 2;
    while (!o_wb_m0_ack && lat < 40) begin
      tick(); lat++;
    end
    i_wb_m0_stb = 1'b0;
    tick();
    i_debug_mode = 1'b0;
    check("midflight_latency", lat, 5);
    wb = '{8'h88, 8'h77, 8'h66, 8'h55};
    for (int k = 0; k < 4; k++) begin
      e.a = AW'(32'h60 + k); e.d = wb[k];
      check("midflight_byte", {11'd0, wlog_at(k)}, {11'd0, e});
    end
    $display("midflight: lat %0d, %0d bytes", lat, wlog.size());

    // Reset during cnt=2 of a read: no ack, enables off, rdt cleared.
    i_wb_m0_adr = 32'h10; i_wb_m0_we = 1'b0; i_wb_m0_stb = 1'b1;
    tick(); tick(); tick();
    check("abort_ren_before", {31'd0, o_sram_ren}, 32'd1);
    i_rst = 1'b1;
    tick();
    check("abort_ack", {30'd0, o_wb_m0_ack, o_wb_m1_ack}, 32'd0);
    check("abort_enables", {30'd0, o_sram_wen, o_sram_ren}, 32'd0);
    check("abort_m0_rdt", o_wb_m0_rdt, 32'd0);
    i_rst = 1'b0; i_wb_m0_stb = 1'b0;
    a0 = 0;
    repeat (10) begin
      tick();
      if (o_wb_m0_ack || o_wb_m1_ack) a0++;
    end
    check("abort_no_late_ack", a0, 0);
    $display("abort: late acks %0d, m0 rdt %h", a0, o_wb_m0_rdt);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
